// File: rtl/cnn_conv_controller.sv
// Sequencer for the CNN convolution datapath: loads the filters, fills the
// row buffer, then runs one 16-cycle MAC per 4x4 window and stores each
// result. All datapath controls are Moore decodes of the state register,
// plus the kernel index for the filter-buffer write select.
//
// Handshake: start is a level that is only looked at in IDLE. Once accepted,
// busy stays high until the run ends. done is a single-cycle pulse in the
// last busy cycle. busy drops on the following cycle. A start that is still
// high at that point begins a new run from INIT.
module cnn_conv_controller #(
   parameter int KERNEL_COUNT = 4,
   parameter int AW           = $clog2(16*KERNEL_COUNT+256),
   parameter int ZW           = $clog2(172)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    cout_filter_write_index,
   input  logic                    cout_mac_index,
   input  logic                    cout_buff_write_index,
   input  logic                    cout_buff_read_index,
   output logic                    load_x,
   output logic                    sel_x,
   output logic                    load_y,
   output logic                    sel_y,
   output logic                    load_z,
   output logic                    sel_z,
   output logic [AW-1:0]           x_inp,
   output logic [AW-1:0]           y_inp,
   output logic [ZW-1:0]           z_inp,
   output logic                    mem_addr_sel,
   output logic                    write_buff_counter_en,
   output logic                    read_buff_counter_en,
   output logic                    shift_buff,
   output logic                    write_buff_en,
   output logic                    write_filter_buff_counter_en,
   output logic                    read_filter_buff_counter_en,
   output logic [KERNEL_COUNT-1:0] write_filter_buff_en,
   output logic                    write_window_buff_en,
   output logic                    partial_res_en,
   output logic                    clear_mac,
   output logic                    shift_reg_en,
   output logic                    mem_write_en,
   output logic                    finalize_shift_reg,
   output logic                    done,
   output logic                    busy,
   output logic [3:0]              dbg_state_o
);

   localparam int KW = (KERNEL_COUNT > 1) ? $clog2(KERNEL_COUNT) : 1;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_INIT    = 4'd1,
      S_F_ADDR  = 4'd2,
      S_F_WR    = 4'd3,
      S_R_SHIFT = 4'd4,
      S_R_ADDR  = 4'd5,
      S_R_WR    = 4'd6,
      S_WIN     = 4'd7,
      S_MAC     = 4'd8,
      S_STORE   = 4'd9,
      S_CLR     = 4'd10,
      S_FIN     = 4'd11,
      S_DONE    = 4'd12
   } state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   kernel_q, kernel_d;   // filter currently being loaded
   logic [3:0]      row_q, row_d;         // window row, 0..12
   logic [2:0]      pend_q, pend_d;       // image rows still to load before next window

   // State and sequencing registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         kernel_q <= '0;
         row_q    <= '0;
         pend_q   <= '0;
      end else begin
         state_q  <= state_d;
         kernel_q <= kernel_d;
         row_q    <= row_d;
         pend_q   <= pend_d;
      end
   end

   // Next-state logic; counter terminal flags are checked in listed priority.
   always_comb begin
      state_d  = state_q;
      kernel_d = kernel_q;
      row_d    = row_q;
      pend_d   = pend_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_INIT;
         S_INIT: begin
            kernel_d = '0;
            row_d    = '0;
            pend_d   = '0;
            state_d  = S_F_ADDR;
         end
         S_F_ADDR:  state_d = S_F_WR;
         S_F_WR: begin
            if (!cout_filter_write_index) begin
               state_d = S_F_ADDR;
            end else if (kernel_q == KW'(KERNEL_COUNT-1)) begin
               pend_d  = 3'd4;
               state_d = S_R_SHIFT;
            end else begin
               kernel_d = kernel_q + 1'b1;
               state_d  = S_F_ADDR;
            end
         end
         S_R_SHIFT: state_d = S_R_ADDR;
         S_R_ADDR:  state_d = S_R_WR;
         S_R_WR: begin
            if (!cout_buff_write_index) begin
               state_d = S_R_ADDR;
            end else begin
               pend_d  = pend_q - 3'd1;
               state_d = (pend_q == 3'd1) ? S_WIN : S_R_SHIFT;
            end
         end
         S_WIN:     state_d = S_MAC;
         S_MAC:     if (cout_mac_index) state_d = S_STORE;
         S_STORE:   state_d = S_CLR;
         S_CLR: begin
            if (!cout_buff_read_index) begin
               state_d = S_WIN;
            end else if (row_q == 4'd12) begin
               state_d = S_FIN;
            end else begin
               row_d   = row_q + 4'd1;
               pend_d  = 3'd1;
               state_d = S_R_SHIFT;
            end
         end
         S_FIN:     state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Moore output decode; every control is low unless its state raises it.
   always_comb begin
      load_x                       = 1'b0;
      sel_x                        = 1'b0;
      load_y                       = 1'b0;
      sel_y                        = 1'b0;
      load_z                       = 1'b0;
      sel_z                        = 1'b0;
      x_inp                        = '0;
      y_inp                        = '0;
      z_inp                        = '0;
      mem_addr_sel                 = 1'b0;
      write_buff_counter_en        = 1'b0;
      read_buff_counter_en         = 1'b0;
      shift_buff                   = 1'b0;
      write_buff_en                = 1'b0;
      write_filter_buff_counter_en = 1'b0;
      read_filter_buff_counter_en  = 1'b0;
      write_filter_buff_en         = '0;
      write_window_buff_en         = 1'b0;
      partial_res_en               = 1'b0;
      clear_mac                    = 1'b0;
      shift_reg_en                 = 1'b0;
      mem_write_en                 = 1'b0;
      finalize_shift_reg           = 1'b0;
      done                         = 1'b0;
      busy                         = (state_q != S_IDLE);
      case (state_q)
         S_INIT: begin
            load_x    = 1'b1;
            x_inp     = AW'(16*KERNEL_COUNT);
            load_y    = 1'b1;
            load_z    = 1'b1;
            clear_mac = 1'b1;
         end
         S_F_ADDR:  mem_addr_sel = 1'b1;
         S_F_WR: begin
            mem_addr_sel                 = 1'b1;
            write_filter_buff_en         = KERNEL_COUNT'(1) << kernel_q;
            write_filter_buff_counter_en = 1'b1;
            load_y                       = 1'b1;
            sel_y                        = 1'b1;
         end
         S_R_SHIFT: shift_buff = 1'b1;
         S_R_WR: begin
            write_buff_en         = 1'b1;
            write_buff_counter_en = 1'b1;
            load_x                = 1'b1;
            sel_x                 = 1'b1;
         end
         S_WIN:     write_window_buff_en = 1'b1;
         S_MAC: begin
            partial_res_en              = 1'b1;
            read_filter_buff_counter_en = 1'b1;
         end
         S_STORE: begin
            shift_reg_en = 1'b1;
            mem_write_en = 1'b1;
            load_z       = 1'b1;
            sel_z        = 1'b1;
         end
         S_CLR: begin
            clear_mac            = 1'b1;
            read_buff_counter_en = 1'b1;
         end
         S_FIN:     finalize_shift_reg = 1'b1;
         S_DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cnn_conv_controller.sv
// Bench for cnn_conv_controller: a small datapath model supplies the counter
// terminal flags, and every cycle's control outputs are compared with a
// cycle-by-cycle schedule built from nested loops over kernels, rows and
// windows.
module tb_cnn_conv_controller;

   localparam int KC = 2;
   localparam int AW = $clog2(16*KC+256);
   localparam int ZW = $clog2(172);
   localparam int P  = 13 + KC;

   // Bit positions of the packed per-cycle output vector.
   localparam logic [63:0] B_LX   = 64'd1 << 0;
   localparam logic [63:0] B_SX   = 64'd1 << 1;
   localparam logic [63:0] B_LY   = 64'd1 << 2;
   localparam logic [63:0] B_SY   = 64'd1 << 3;
   localparam logic [63:0] B_LZ   = 64'd1 << 4;
   localparam logic [63:0] B_SZ   = 64'd1 << 5;
   localparam logic [63:0] B_MSEL = 64'd1 << 6;
   localparam logic [63:0] B_WBC  = 64'd1 << 7;
   localparam logic [63:0] B_RBC  = 64'd1 << 8;
   localparam logic [63:0] B_SHF  = 64'd1 << 9;
   localparam logic [63:0] B_WBE  = 64'd1 << 10;
   localparam logic [63:0] B_WFC  = 64'd1 << 11;
   localparam logic [63:0] B_RFC  = 64'd1 << 12;
   localparam logic [63:0] B_WWB  = 64'd1 << P;
   localparam logic [63:0] B_PRE  = 64'd1 << (P+1);
   localparam logic [63:0] B_CLR  = 64'd1 << (P+2);
   localparam logic [63:0] B_SRE  = 64'd1 << (P+3);
   localparam logic [63:0] B_MWE  = 64'd1 << (P+4);
   localparam logic [63:0] B_FIN  = 64'd1 << (P+5);
   localparam logic [63:0] B_DONE = 64'd1 << (P+6);
   localparam logic [63:0] B_BUSY = 64'd1 << (P+7);
   localparam logic [63:0] X_INIT = 64'(16*KC) << (P+8);

   logic clk, rst, start;
   logic cout_filter_write_index, cout_mac_index, cout_buff_write_index, cout_buff_read_index;
   logic load_x, sel_x, load_y, sel_y, load_z, sel_z;
   logic [AW-1:0] x_inp, y_inp;
   logic [ZW-1:0] z_inp;
   logic mem_addr_sel, write_buff_counter_en, read_buff_counter_en, shift_buff, write_buff_en;
   logic write_filter_buff_counter_en, read_filter_buff_counter_en;
   logic [KC-1:0] write_filter_buff_en;
   logic write_window_buff_en, partial_res_en, clear_mac, shift_reg_en, mem_write_en;
   logic finalize_shift_reg, done, busy;
   logic [3:0] dbg_state;

   cnn_conv_controller #(.KERNEL_COUNT(KC)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cout_filter_write_index(cout_filter_write_index),
      .cout_mac_index(cout_mac_index),
      .cout_buff_write_index(cout_buff_write_index),
      .cout_buff_read_index(cout_buff_read_index),
      .load_x(load_x), .sel_x(sel_x), .load_y(load_y), .sel_y(sel_y),
      .load_z(load_z), .sel_z(sel_z),
      .x_inp(x_inp), .y_inp(y_inp), .z_inp(z_inp),
      .mem_addr_sel(mem_addr_sel),
      .write_buff_counter_en(write_buff_counter_en),
      .read_buff_counter_en(read_buff_counter_en),
      .shift_buff(shift_buff), .write_buff_en(write_buff_en),
      .write_filter_buff_counter_en(write_filter_buff_counter_en),
      .read_filter_buff_counter_en(read_filter_buff_counter_en),
      .write_filter_buff_en(write_filter_buff_en),
      .write_window_buff_en(write_window_buff_en),
      .partial_res_en(partial_res_en), .clear_mac(clear_mac),
      .shift_reg_en(shift_reg_en), .mem_write_en(mem_write_en),
      .finalize_shift_reg(finalize_shift_reg),
      .done(done), .busy(busy), .dbg_state_o(dbg_state)
   );

   // Clock and datapath counter model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int fw_cnt, mac_cnt, bw_cnt, rd_cnt, z_model;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         fw_cnt  <= 0;
         mac_cnt <= 0;
         bw_cnt  <= 0;
         rd_cnt  <= 0;
         z_model <= 0;
      end else begin
         if (write_filter_buff_counter_en) fw_cnt  <= (fw_cnt + 1) % 4;
         if (read_filter_buff_counter_en)  mac_cnt <= (mac_cnt + 1) % 16;
         if (write_buff_counter_en)        bw_cnt  <= (bw_cnt + 1) % 4;
         if (read_buff_counter_en)         rd_cnt  <= (rd_cnt == 12) ? 0 : rd_cnt + 1;
         if (load_z) z_model <= sel_z ? z_model + 1 : int'(z_inp);
      end
   end

   assign cout_filter_write_index = (fw_cnt == 3);
   assign cout_mac_index          = (mac_cnt == 15);
   assign cout_buff_write_index   = (bw_cnt == 3);
   assign cout_buff_read_index    = (rd_cnt == 12);

   // Scoreboard
   logic [63:0] exp_q[$];
   int n_vec, n_err, exp_z;
   int cnt_mwe, cnt_rbc, cnt_fin, cnt_shf, cnt_wbe, cnt_yinc, cnt_done;
   int pre_shf, pre_wbe;
   bit seen_win;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack();
      return 64'({z_inp, y_inp, x_inp, busy, done, finalize_shift_reg, mem_write_en,
                  shift_reg_en, clear_mac, partial_res_en, write_window_buff_en,
                  write_filter_buff_en, read_filter_buff_counter_en,
                  write_filter_buff_counter_en, write_buff_en, shift_buff,
                  read_buff_counter_en, write_buff_counter_en, mem_addr_sel,
                  sel_z, load_z, sel_y, load_y, sel_x, load_x});
   endfunction

   // One row load: a shift, then four address/write word pairs.
   task automatic push_row();
      exp_q.push_back(B_BUSY | B_SHF);
      for (int w = 0; w < 4; w++) begin
         exp_q.push_back(B_BUSY);
         exp_q.push_back(B_BUSY | B_WBE | B_WBC | B_LX | B_SX);
      end
   endtask

   // Full expected schedule of one run, starting with the INIT cycle.
   task automatic gen_run();
      exp_q.push_back(B_BUSY | B_LX | B_LY | B_LZ | B_CLR | X_INIT);
      for (int k = 0; k < KC; k++)
         for (int w = 0; w < 4; w++) begin
            exp_q.push_back(B_BUSY | B_MSEL);
            exp_q.push_back(B_BUSY | B_MSEL | (64'd1 << (13+k)) | B_WFC | B_LY | B_SY);
         end
      for (int r = 0; r < 4; r++) push_row();
      for (int row = 0; row < 13; row++) begin
         if (row > 0) push_row();
         for (int col = 0; col < 13; col++) begin
            exp_q.push_back(B_BUSY | B_WWB);
            for (int m = 0; m < 16; m++) exp_q.push_back(B_BUSY | B_PRE | B_RFC);
            exp_q.push_back(B_BUSY | B_SRE | B_MWE | B_LZ | B_SZ);
            exp_q.push_back(B_BUSY | B_CLR | B_RBC);
         end
      end
      exp_q.push_back(B_BUSY | B_FIN);
      exp_q.push_back(B_BUSY | B_DONE);
   endtask

   task automatic clear_counts();
      cnt_mwe = 0; cnt_rbc = 0; cnt_fin = 0; cnt_shf = 0; cnt_wbe = 0;
      cnt_yinc = 0; cnt_done = 0; pre_shf = 0; pre_wbe = 0; seen_win = 1'b0;
      exp_z = 0;
   endtask

   // Advance one cycle, compare against the schedule, tally events.
   task automatic step();
      logic [63:0] e;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_eq("cycle", pack(), e);
      if (mem_write_en) begin
         check_eq("z_addr", 64'(z_model), 64'(exp_z));
         exp_z = (exp_z + 1) % 169;
      end
      if (write_window_buff_en && !seen_win) begin
         seen_win = 1'b1;
         pre_shf  = cnt_shf;
         pre_wbe  = cnt_wbe;
      end
      if (mem_write_en)         cnt_mwe++;
      if (read_buff_counter_en) cnt_rbc++;
      if (finalize_shift_reg)   cnt_fin++;
      if (shift_buff)           cnt_shf++;
      if (write_buff_en)        cnt_wbe++;
      if (load_y && sel_y)      cnt_yinc++;
      if (done)                 cnt_done++;
   endtask

   // Idle gap, start, n back-to-back runs (start held for n>1), then idle.
   task automatic run_seq(input int n_runs, input string tag);
      int idle, len, drop_at, steps;
      exp_q.delete();
      clear_counts();
      idle = $urandom_range(1, 6);
      repeat (idle) exp_q.push_back(64'd0);
      while (exp_q.size() > 0) step();
      start = 1'b1;
      gen_run();
      len = exp_q.size();
      for (int r = 1; r < n_runs; r++) begin
         exp_q.push_back(64'd0);
         gen_run();
      end
      drop_at = (n_runs == 1) ? $urandom_range(1, 3) : len + 2;
      steps = 0;
      while (exp_q.size() > 0) begin
         step();
         steps++;
         if (steps == drop_at) start = 1'b0;
      end
      exp_q.push_back(64'd0);
      step();
      check_eq({tag, "_mem_write_cnt"}, 64'(cnt_mwe), 64'(169*n_runs));
      check_eq({tag, "_rd_buf_cnt"},    64'(cnt_rbc), 64'(169*n_runs));
      check_eq({tag, "_finalize_cnt"},  64'(cnt_fin), 64'(n_runs));
      check_eq({tag, "_shift_cnt"},     64'(cnt_shf), 64'(16*n_runs));
      check_eq({tag, "_row_word_cnt"},  64'(cnt_wbe), 64'(64*n_runs));
      check_eq({tag, "_y_inc_cnt"},     64'(cnt_yinc), 64'(4*KC*n_runs));
      check_eq({tag, "_done_cnt"},      64'(cnt_done), 64'(n_runs));
      check_eq({tag, "_pre_win_shift"}, 64'(pre_shf), 64'd4);
      check_eq({tag, "_pre_win_words"}, 64'(pre_wbe), 64'd16);
      check_eq({tag, "_final_z"},       64'(z_model), 64'd169);
      check_eq({tag, "_idle_state"},    64'(dbg_state), 64'd0);
   endtask

   // Start a run and pull reset asynchronously somewhere inside the first MAC.
   task automatic reset_mid_mac();
      int n;
      exp_q.delete();
      clear_counts();
      start = 1'b1;
      gen_run();
      n = 54 + $urandom_range(1, 15);
      for (int i = 0; i < n; i++) begin
         step();
         if (i == 0) start = 1'b0;
      end
      check_eq("in_mac_pre_reset", 64'(partial_res_en), 64'd1);
      #($urandom_range(1, 6));
      rst = 1'b0;
      #1;
      check_eq("async_reset_outputs", pack(), 64'd0);
      check_eq("async_reset_state", 64'(dbg_state), 64'd0);
      @(posedge clk);
      #2;
      check_eq("held_reset_outputs", pack(), 64'd0);
      rst = 1'b1;
      exp_q.delete();
   endtask

   // Main sequence
   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      start = 1'b0;
      clear_counts();
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_outputs", pack(), 64'd0);
      check_eq("reset_state", 64'(dbg_state), 64'd0);
      start = 1'b1;
      @(posedge clk);
      #1;
      check_eq("start_in_reset", pack(), 64'd0);
      start = 1'b0;
      rst   = 1'b1;

      run_seq(1, "run_a");
      reset_mid_mac();
      run_seq(1, "after_reset");
      run_seq(2, "start_held");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cnn_conv_controller.md
Name: cnn_conv_controller

Overview:
- Sequencer FSM for the CNN convolution datapath.
- Loads KERNEL_COUNT 4x4 filters into the PE filter buffers, then streams a 16x16 image through the 4x16 row buffer and the 4x4 window.
- Drives one 16-cycle MAC per window and writes each of the 13x13 = 169 results per kernel to the PE output memories.
- Sits between a top-level start/done handshake and the datapath control inputs.

Parameters:
- KERNEL_COUNT, 4, number of PEs/filters; filters occupy bytes 0..16*KERNEL_COUNT-1, image occupies the next 256 bytes.
- AW, $clog2(16*KERNEL_COUNT+256), byte address width for x/y address counters.
- ZW, $clog2(172), output-address width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  level; sampled in IDLE only.
- cout_filter_write_index  input  1  filter-word counter at 3.
- cout_mac_index  input  1  MAC counter at 15.
- cout_buff_write_index  input  1  buffer-word counter at 3.
- cout_buff_read_index  input  1  window-column counter at 12.
- load_x, sel_x, load_y, sel_y, load_z, sel_z  output  1 each  address counter enables/selects; sel=0 loads init value, sel=1 increments (x,y by 4, z by 1).
- x_inp, y_inp  output  AW  init addresses.
- z_inp  output  ZW  init output address.
- mem_addr_sel  output  1  0 = x (image), 1 = y (filter).
- write_buff_counter_en, read_buff_counter_en, shift_buff, write_buff_en  output  1 each  row-buffer control.
- write_filter_buff_counter_en, read_filter_buff_counter_en  output  1 each  filter/MAC counters.
- write_filter_buff_en  output  KERNEL_COUNT  one-hot filter-buffer write select, bit 0 = PE 1.
- write_window_buff_en, partial_res_en, clear_mac, shift_reg_en, mem_write_en, finalize_shift_reg  output  1 each.
- done  output  1  one-cycle pulse at completion.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, any time, async): state=IDLE, kernel index=0, row count=0. All outputs 0; x_inp, y_inp, z_inp = 0.
- All outputs are Moore decodes of state plus internal kernel index; unlisted outputs are 0.
- Memory read is synchronous, one cycle. Each word takes an ADDR cycle (address stable) then a WR cycle (write strobe plus counter/address increment).
- IDLE: start=1 -> INIT. start while busy is ignored.
- INIT (1 cycle):
  - load_x/sel_x=0, x_inp=16*KERNEL_COUNT.
  - load_y/sel_y=0, y_inp=0.
  - load_z/sel_z=0, z_inp=0.
  - clear_mac=1.
  - -> F_ADDR.
- F_ADDR: mem_addr_sel=1 -> F_WR.
- F_WR:
  - mem_addr_sel=1, write_filter_buff_en = one-hot(kernel), write_filter_buff_counter_en=1, load_y=1, sel_y=1.
  - If cout_filter_write_index=0 -> F_ADDR.
  - Else if kernel = KERNEL_COUNT-1 -> R_SHIFT (rows_pending=4).
  - Else kernel++ and -> F_ADDR.
- R_SHIFT: shift_buff=1 -> R_ADDR.
- R_ADDR: mem_addr_sel=0 -> R_WR.
- R_WR:
  - write_buff_en=1, write_buff_counter_en=1, load_x=1, sel_x=1.
  - If cout_buff_write_index=0 -> R_ADDR.
  - Else rows_pending--; if rows_pending reaches 0 -> WIN, else -> R_SHIFT.
- WIN (1 cycle): write_window_buff_en=1 -> MAC.
- MAC:
  - partial_res_en=1, read_filter_buff_counter_en=1.
  - Exit to STORE on the cycle cout_mac_index=1. Exactly 16 MAC cycles.
- STORE: shift_reg_en=1, mem_write_en=1, load_z=1, sel_z=1 -> CLR.
- CLR: clear_mac=1, read_buff_counter_en=1.
  - If cout_buff_read_index=0 -> WIN.
  - Else if row count=12 -> FIN.
  - Else row count++, rows_pending=1 -> R_SHIFT.
  - The window-column counter wraps 12->0 in the CLR cycle.
- FIN: finalize_shift_reg=1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. busy is low from the following cycle.
- Totals per run:
  - 4*KERNEL_COUNT filter words, 16+12*4 = 64 image words.
  - 169 windows, 169 mem_write_en pulses.
  - Final z = 169.
- Simultaneous events: coincident couts are resolved by the priority order written above. start arriving during DONE is not sampled until IDLE.

Test Plan:
- Reset mid-MAC (rst low for 1 cycle, asynchronous to clk) -> all outputs 0 immediately, state IDLE; a fresh start completes normally.
- KERNEL_COUNT=2, start pulse -> write_filter_buff_en shows 01 for 4 WR cycles then 10 for 4; y increments 8 times; mem_addr_sel=1 throughout.
- Initial row fill -> exactly 4 shift_buff pulses and 16 write_buff_en pulses before the first write_window_buff_en.
- Per window -> write_window_buff_en, then partial_res_en high exactly 16 consecutive cycles, then mem_write_en 1 cycle, then clear_mac 1 cycle.
- Full run -> mem_write_en count=169, z sequence 0..168, read_buff_counter_en count=169, 12 single-row reloads, finalize_shift_reg once.
- Completion -> done pulses exactly 1 cycle, then busy=0. start held high across completion -> second run begins from INIT with z_inp=0.
